// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared widths, FSM encoding and default timeout for the SDRAM arbiter
package sdram_pkg;
  localparam int ADDR_W          = 26;
  localparam int DATA_W          = 16;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2,
    DONE      = 2'd3
  } state_t;
endpackage

// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - SDRAM controller and two-requester signal bundle
interface sdram_arbiter_if;
  import sdram_pkg::*;

  logic [ADDR_W-1:0] sdram_addr;
  logic [1:0]        sdram_byteenable_n;
  logic              sdram_chipselect;
  logic [DATA_W-1:0] sdram_writedata;
  logic              sdram_read_n;
  logic              sdram_write_n;
  logic [DATA_W-1:0] sdram_readdata;
  logic              sdram_readdata_valid;
  logic              sdram_waitrequest;

  logic              p0_request, p1_request;
  logic [ADDR_W-1:0] p0_address, p1_address;
  logic              p0_write, p1_write;
  logic [DATA_W-1:0] p0_writedata, p1_writedata;
  logic              p0_done, p1_done;
  logic [DATA_W-1:0] p0_readdata, p1_readdata;
  logic              p0_error, p1_error;

  // master is the arbiter; slave is the controller plus both requesters
  modport master (
    output sdram_addr, sdram_byteenable_n, sdram_chipselect, sdram_writedata,
    output sdram_read_n, sdram_write_n,
    input  sdram_readdata, sdram_readdata_valid, sdram_waitrequest,
    input  p0_request, p0_address, p0_write, p0_writedata,
    input  p1_request, p1_address, p1_write, p1_writedata,
    output p0_done, p0_readdata, p0_error,
    output p1_done, p1_readdata, p1_error
  );

  modport slave (
    input  sdram_addr, sdram_byteenable_n, sdram_chipselect, sdram_writedata,
    input  sdram_read_n, sdram_write_n,
    output sdram_readdata, sdram_readdata_valid, sdram_waitrequest,
    output p0_request, p0_address, p0_write, p0_writedata,
    output p1_request, p1_address, p1_write, p1_writedata,
    input  p0_done, p0_readdata, p0_error,
    input  p1_done, p1_readdata, p1_error
  );
endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin pick; a tie goes to the port not granted last
module rr_arbiter2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_grant
);
  assign o_grant = (i_req0 && i_req1) ? ~i_last : i_req1;
endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - shares one SDRAM controller between two requesters, one transfer at a time
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic           clock_50,
  input  logic           reset_50,
  sdram_arbiter_if.master bus
);
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            r_state, w_next;
  logic              r_gnt, r_last, r_write, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata0, r_rdata1;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_any_req, w_gnt, w_timeout;

  assign w_any_req = bus.p0_request | bus.p1_request;
  assign w_timeout = (r_cnt == CNT_LAST);

  rr_arbiter2 u_rr (
    .i_req0  (bus.p0_request),
    .i_req1  (bus.p1_request),
    .i_last  (r_last),
    .o_grant (w_gnt)
  );

  always_ff @(posedge clock_50) begin
    if (reset_50) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_any_req) w_next = ISSUE;
      ISSUE:     if (!bus.sdram_waitrequest) w_next = r_write ? DONE : WAIT_DATA;
      WAIT_DATA: if (bus.sdram_readdata_valid || w_timeout) w_next = DONE;
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_50) begin
    if (reset_50) begin
      r_gnt    <= 1'b0;
      r_last   <= 1'b1;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any_req) begin
          r_gnt   <= w_gnt;
          r_addr  <= w_gnt ? bus.p1_address   : bus.p0_address;
          r_write <= w_gnt ? bus.p1_write     : bus.p0_write;
          r_wdata <= w_gnt ? bus.p1_writedata : bus.p0_writedata;
          r_err   <= 1'b0;
        end
        ISSUE: r_cnt <= '0;
        // valid data wins over a timeout landing on the same edge
        WAIT_DATA: begin
          r_cnt <= r_cnt + 1'b1;
          if (bus.sdram_readdata_valid) begin
            r_err <= 1'b0;
            if (r_gnt) r_rdata1 <= bus.sdram_readdata;
            else       r_rdata0 <= bus.sdram_readdata;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        DONE: r_last <= r_gnt;
        default: ;
      endcase
    end
  end

  assign bus.sdram_byteenable_n = 2'b00;
  assign bus.sdram_chipselect   = 1'b1;
  assign bus.sdram_addr         = r_addr;
  assign bus.sdram_writedata    = r_wdata;
  assign bus.sdram_read_n       = !((r_state == ISSUE) && !r_write);
  assign bus.sdram_write_n      = !((r_state == ISSUE) &&  r_write);

  assign bus.p0_done     = (r_state == DONE) && !r_gnt;
  assign bus.p1_done     = (r_state == DONE) &&  r_gnt;
  assign bus.p0_error    = bus.p0_done && r_err;
  assign bus.p1_error    = bus.p1_done && r_err;
  assign bus.p0_readdata = r_rdata0;
  assign bus.p1_readdata = r_rdata1;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - randomized transaction bench with a transaction-level reference model
module tb_sdram_arbiter;
  import sdram_pkg::*;

  localparam int TMO = 8;

  logic clock_50 = 1'b0;
  logic reset_50;
  int   n_cmp = 0;
  int   n_bad = 0;

  bit          m_last;
  logic [15:0] m_rd [2];

  sdram_arbiter_if bus ();

  sdram_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock_50 (clock_50),
    .reset_50 (reset_50),
    .bus      (bus)
  );

  always #5 clock_50 = ~clock_50;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state();
    check_val("rst_read_n",  bus.sdram_read_n, 1);
    check_val("rst_write_n", bus.sdram_write_n, 1);
    check_val("rst_addr",    bus.sdram_addr, 0);
    check_val("rst_wdata",   bus.sdram_writedata, 0);
    check_val("rst_done0",   bus.p0_done, 0);
    check_val("rst_done1",   bus.p1_done, 0);
    check_val("rst_err0",    bus.p0_error, 0);
    check_val("rst_err1",    bus.p1_error, 0);
    check_val("rst_rd0",     bus.p0_readdata, 0);
    check_val("rst_rd1",     bus.p1_readdata, 0);
    check_val("rst_cs",      bus.sdram_chipselect, 1);
    check_val("rst_be_n",    bus.sdram_byteenable_n, 0);
  endtask

  // One arbitrated transfer. waits = waitrequest-high cycles in ISSUE, lat = WAIT_DATA
  // cycle index carrying valid data (>= TMO means none), rst_at = WAIT_DATA cycle to reset in.
  task automatic run_txn(input bit r0, input bit r1, input bit w0, input bit w1,
                         input logic [25:0] a0, input logic [25:0] a1,
                         input logic [15:0] d0, input logic [15:0] d1,
                         input int waits, input int lat, input logic [15:0] rdata,
                         input int rst_at);
    int          g;
    bit          w, ok, err;
    logic [25:0] a;
    logic [15:0] d;

    @(negedge clock_50);
    bus.p0_request = r0; bus.p0_write = w0; bus.p0_address = a0; bus.p0_writedata = d0;
    bus.p1_request = r1; bus.p1_write = w1; bus.p1_address = a1; bus.p1_writedata = d1;
    bus.sdram_waitrequest = 1'b1;
    bus.sdram_readdata_valid = 1'b0;

    g = (r0 && r1) ? (m_last ? 0 : 1) : (r1 ? 1 : 0);
    w = g ? w1 : w0;
    a = g ? a1 : a0;
    d = g ? d1 : d0;
    @(posedge clock_50);

    for (int c = 0; c <= waits; c++) begin
      @(negedge clock_50);
      check_val("cmd_read_n",  bus.sdram_read_n, w);
      check_val("cmd_write_n", bus.sdram_write_n, !w);
      check_val("cmd_addr",    bus.sdram_addr, a);
      if (w) check_val("cmd_wdata", bus.sdram_writedata, d);
      check_val("issue_no_done", {bus.p1_done, bus.p0_done}, 0);
      bus.p0_request = 1'b0; bus.p1_request = 1'b0;
      bus.p0_address = 26'($urandom); bus.p1_address = 26'($urandom);
      bus.p0_writedata = 16'($urandom); bus.p1_writedata = 16'($urandom);
      bus.p0_write = 1'($urandom); bus.p1_write = 1'($urandom);
      bus.sdram_waitrequest = (c < waits);
      bus.sdram_readdata_valid = 1'($urandom);
      bus.sdram_readdata = 16'($urandom);
      @(posedge clock_50);
    end

    @(negedge clock_50);
    check_val("cmd_release", {bus.sdram_read_n, bus.sdram_write_n}, 2'b11);
    bus.sdram_readdata_valid = 1'b0;
    ok = 1'b1;
    if (!w) begin
      ok = 1'b0;
      for (int i = 0; i < TMO; i++) begin
        if (i > 0) @(negedge clock_50);
        check_val("wait_no_done", {bus.p1_done, bus.p0_done}, 0);
        if (i == rst_at) begin
          reset_50 = 1'b1;
          bus.sdram_readdata_valid = 1'b0;
          @(posedge clock_50);
          @(negedge clock_50);
          reset_50 = 1'b0;
          bus.sdram_readdata_valid = 1'b1;
          bus.sdram_readdata = 16'hDEAD;
          m_last = 1'b1;
          m_rd[0] = '0;
          m_rd[1] = '0;
          check_reset_state();
          @(posedge clock_50);
          @(negedge clock_50);
          bus.sdram_readdata_valid = 1'b0;
          check_reset_state();
          return;
        end
        bus.sdram_readdata_valid = (i == lat);
        bus.sdram_readdata = (i == lat) ? rdata : 16'($urandom);
        @(posedge clock_50);
        if (i == lat) begin
          ok = 1'b1;
          break;
        end
      end
      @(negedge clock_50);
      if (ok) m_rd[g] = rdata;
    end
    err = !ok;
    check_val("done0",  bus.p0_done,  g == 0);
    check_val("done1",  bus.p1_done,  g == 1);
    check_val("error0", bus.p0_error, (g == 0) && err);
    check_val("error1", bus.p1_error, (g == 1) && err);
    check_val("rdata0", bus.p0_readdata, m_rd[0]);
    check_val("rdata1", bus.p1_readdata, m_rd[1]);
    bus.sdram_readdata_valid = 1'($urandom);
    bus.sdram_readdata = 16'($urandom);
    m_last = (g == 1);
  endtask

  initial begin
    bus.p0_request = 0; bus.p0_address = 0; bus.p0_write = 0; bus.p0_writedata = 0;
    bus.p1_request = 0; bus.p1_address = 0; bus.p1_write = 0; bus.p1_writedata = 0;
    bus.sdram_readdata = 0; bus.sdram_readdata_valid = 0; bus.sdram_waitrequest = 1;
    reset_50 = 1'b1;
    m_last = 1'b1;
    m_rd[0] = '0;
    m_rd[1] = '0;
    repeat (3) @(posedge clock_50);
    @(negedge clock_50);
    reset_50 = 1'b0;
    check_reset_state();

    run_txn(1, 0, 0, 0, 26'h0000123, 26'h0, 16'h0, 16'h0, 3, 2, 16'hBEEF, -1);
    run_txn(0, 1, 0, 1, 26'h0, 26'h3FFFFFF, 16'h0, 16'h5A5A, 0, 0, 16'h0, -1);
    run_txn(1, 0, 0, 0, 26'h0000055, 26'h0, 16'h0, 16'h0, 1, 100, 16'h1111, -1);
    run_txn(1, 0, 0, 0, 26'h0000056, 26'h0, 16'h0, 16'h0, 0, 7, 16'h2222, -1);

    for (int k = 0; k < 6; k++)
      run_txn(1, 1, 0, 0, 26'($urandom), 26'($urandom), 16'h0, 16'h0,
              $urandom_range(0, 2), $urandom_range(0, 4), 16'($urandom), -1);

    run_txn(1, 1, 0, 0, 26'h1AB, 26'h2CD, 16'h0, 16'h0, 1, 100, 16'h0, 3);
    run_txn(1, 1, 1, 1, 26'h3, 26'h4, 16'hA0A0, 16'hB0B0, 0, 0, 16'h0, -1);

    for (int k = 0; k < 60; k++) begin
      bit r0, r1;
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      run_txn(r0, r1, 1'($urandom), 1'($urandom), 26'($urandom), 26'($urandom),
              16'($urandom), 16'($urandom), $urandom_range(0, 4),
              $urandom_range(0, 11), 16'($urandom), -1);
    end

    @(negedge clock_50);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Param TIMEOUT_CYCLES, default 255: maximum clock_50 cycles spent in WAIT_DATA before a read is aborted.
REQ-002 clock_50  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-003 reset_50  in  1  reset; synchronous, active-high.
REQ-004 sdram_addr  out  26  word address to the SDRAM controller.
REQ-005 sdram_byteenable_n  out  2  byte enables, active-low.
REQ-006 sdram_chipselect  out  1  chip select.
REQ-007 sdram_writedata  out  16  write data.
REQ-008 sdram_read_n / sdram_write_n  out  1 each  commands, active-low.
REQ-009 sdram_readdata  in  16 / sdram_readdata_valid  in  1 / sdram_waitrequest  in  1  controller returns.
REQ-010 pN_request  in  1  (N=0,1) level request from requester N.
REQ-011 pN_address  in  26 / pN_write  in  1 / pN_writedata  in  16  transfer descriptor from requester N; pN_write=1 selects write.
REQ-012 pN_done  out  1  one-cycle completion pulse to requester N.
REQ-013 pN_readdata  out  16  last read result for requester N.
REQ-014 pN_error  out  1  qualifies pN_done: 1 means read timeout.

Function
REQ-015 sdram_byteenable_n SHALL be 2'b00 and sdram_chipselect SHALL be 1 at all times.
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT_DATA, DONE.
REQ-017 IDLE: when any pN_request=1, the arbiter SHALL grant one port, latch its address, write flag and writedata, and move to ISSUE.
REQ-018 Arbitration SHALL be round-robin: when both ports request, the port not granted most recently wins; after reset, port 0 wins the first tie.
REQ-019 ISSUE: sdram_read_n or sdram_write_n (per the latched flag) SHALL be low, with sdram_addr and sdram_writedata driven from the latched values and held stable while sdram_waitrequest=1.
REQ-020 Latency: a request sampled in IDLE at edge N SHALL assert the command from edge N+1.
REQ-021 At the first edge in ISSUE with sdram_waitrequest=0, the command SHALL deassert; a write SHALL go to DONE and a read SHALL go to WAIT_DATA with the timeout counter cleared.
REQ-022 WAIT_DATA: on sdram_readdata_valid=1, sdram_readdata SHALL be captured into the granted port's pN_readdata and the FSM SHALL go to DONE with error=0.
REQ-023 WAIT_DATA: when the counter reaches TIMEOUT_CYCLES without valid data, the FSM SHALL go to DONE with error=1, leaving pN_readdata unchanged.
REQ-024 DONE lasts exactly one cycle: granted pN_done=1 and pN_error as recorded; the other port's done=0; last-grant is updated; next state is IDLE.
REQ-025 sdram_readdata_valid outside WAIT_DATA SHALL be ignored.
REQ-026 Requester inputs SHALL be ignored outside IDLE; a request still high in IDLE after DONE SHALL be treated as a new request.
REQ-027 pN_readdata SHALL hold its value until the next successful read for that port.

Reset
REQ-028 On reset_50=1 at an edge: state=IDLE, read_n=write_n=1, sdram_addr=0, sdram_writedata=0, all pN_done=0, pN_error=0, pN_readdata=0, counter=0, last-grant=port 1.
REQ-029 Reset mid-transfer SHALL abandon the transfer with no done pulse; any later readdata_valid SHALL be ignored per REQ-025.

Structure
REQ-030 Package sdram_pkg SHALL hold the state enum, address and data width constants, and the default TIMEOUT_CYCLES.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter2 (inputs: two requests and last-grant; output: grant index).

Verification
REQ-032 Port 0 read of 0x0000123, waitrequest high for 3 cycles, valid with 0xBEEF 2 cycles later -> read_n low exactly 4 cycles, p0_done pulse 1 cycle, p0_readdata=0xBEEF, p0_error=0.
REQ-033 Both ports request reads continuously -> grants alternate 0,1,0,1 and neither port is starved.
REQ-034 Port 1 write of 0x5A5A to 0x3FFFFFF, waitrequest=0 -> write_n low 1 cycle, address and data correct, p1_done 1 cycle after acceptance.
REQ-035 Read with no valid data and TIMEOUT_CYCLES=8 -> p0_done=1 with p0_error=1 after 8 WAIT_DATA cycles; a stray valid afterwards is ignored.
REQ-036 reset_50 pulsed during WAIT_DATA -> read_n=1 next edge, no done pulse, all outputs at reset values, next tie grants port 0.
REQ-037 Change p0_address while in ISSUE with waitrequest=1 -> sdram_addr stays at the latched value.
